// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared types and defaults for the memory bus arbiter.
//   state_t : arbiter FSM states (IDLE, MEM, LOCAL)
//   req_t   : one latched requester transaction (addr, wdata, wstrb, instr)
//   DEF_*   : default memory map and watchdog values
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_LOCAL = 2'd2
    } state_t;

    localparam logic [31:0] DEF_MEM_SIZE     = 32'h0010_0000;
    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
    localparam int          DEF_TIMEOUT      = 1024;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority encoder.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot winner (first set bit from ptr upward, wrapping)
//   idx   : binary index of the winner
//   any   : at least one request is pending
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            pos;
    logic [IW-1:0] pos_idx;

    // Walk the requesters starting at ptr; the first hit wins and later
    // hits are ignored, so the grant is always one-hot.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (!any && req[pos_idx]) begin
                any            = 1'b1;
                grant[pos_idx] = 1'b1;
                idx            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Round-robin arbiter sharing one native-interface memory between NUM_REQ
// requesters. Console writes and out-of-range accesses are completed
// locally; a watchdog retires memory accesses that are never acknowledged.
//   clk, resetn          : clock, synchronous active-low reset
//   req_* (packed)       : per-requester valid/instr/addr/wdata/wstrb in,
//                          one-hot req_ready and shared req_rdata out
//   mem_*                : downstream native memory interface
//   console_valid/data   : one-cycle pulse with the written console byte
//   err_valid/addr/timeout : error pulse; address and cause held until
//                          the next error
//   grant_id             : current or last granted requester
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int          NUM_REQ      = 2,
    parameter logic [31:0] MEM_SIZE     = DEF_MEM_SIZE,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
    parameter int          TIMEOUT      = DEF_TIMEOUT,
    localparam int         IW           = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_instr,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    input  logic [4*NUM_REQ-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [31:0]             req_rdata,
    output logic                    mem_valid,
    output logic                    mem_instr,
    input  logic                    mem_ready,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic [31:0]             mem_rdata,
    output logic                    console_valid,
    output logic [7:0]              console_data,
    output logic                    err_valid,
    output logic [31:0]             err_addr,
    output logic                    err_timeout,
    output logic [IW-1:0]           grant_id
);

    localparam int WW = $clog2(TIMEOUT) + 1;

    state_t        state, next_state;
    logic [IW-1:0] rr_ptr;
    req_t          cur, win;
    logic [WW-1:0] wdog;
    logic [31:0]   err_addr_q;
    logic          err_to_q;
    logic          err_is_to;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               win_local;
    logic               timeout_hit;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // AND-OR mux of the winning requester's fields, driven by the one-hot grant.
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                win.addr  = req_addr[32*i +: 32];
                win.wdata = req_wdata[32*i +: 32];
                win.wstrb = req_wstrb[4*i +: 4];
                win.instr = req_instr[i];
            end
        end
    end

    // The console word is above MEM_SIZE, so it must be recognised before
    // the range check treats it as an error.
    assign win_local   = (win.addr == CONSOLE_ADDR) || (win.addr >= MEM_SIZE);
    assign timeout_hit = (state == ST_MEM) && (wdog == WW'(TIMEOUT - 1)) && !mem_ready;

    assign mem_valid = (state == ST_MEM);
    assign mem_instr = cur.instr;
    assign mem_addr  = cur.addr;
    assign mem_wdata = cur.wdata;
    assign mem_wstrb = cur.wstrb;

    // Error details track the pulse combinationally and then hold.
    assign err_addr    = err_valid ? cur.addr : err_addr_q;
    assign err_timeout = err_valid ? err_is_to : err_to_q;

    always_comb begin
        next_state    = state;
        req_ready     = '0;
        req_rdata     = '0;
        console_valid = 1'b0;
        console_data  = '0;
        err_valid     = 1'b0;
        err_is_to     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    next_state = win_local ? ST_LOCAL : ST_MEM;
                end
            end
            ST_MEM: begin
                // A late mem_ready in the watchdog cycle still wins.
                if (mem_ready) begin
                    req_ready[grant_id] = 1'b1;
                    req_rdata           = mem_rdata;
                    next_state          = ST_IDLE;
                end else if (timeout_hit) begin
                    req_ready[grant_id] = 1'b1;
                    err_valid           = 1'b1;
                    err_is_to           = 1'b1;
                    next_state          = ST_IDLE;
                end
            end
            ST_LOCAL: begin
                req_ready[grant_id] = 1'b1;
                next_state          = ST_IDLE;
                if (cur.addr == CONSOLE_ADDR) begin
                    if (|cur.wstrb) begin
                        console_valid = 1'b1;
                        console_data  = cur.wdata[7:0];
                    end
                end else begin
                    err_valid = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Any completion moves priority to the requester after the one served,
    // which makes the just-served requester the lowest priority next round.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            cur        <= '0;
            wdog       <= '0;
            err_addr_q <= '0;
            err_to_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && pick_any) begin
                cur      <= win;
                grant_id <= pick_idx;
                wdog     <= '0;
            end else if (state == ST_MEM) begin
                wdog <= wdog + WW'(1);
            end
            if (|req_ready) begin
                rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
            end
            if (err_valid) begin
                err_addr_q <= cur.addr;
                err_to_q   <= err_is_to;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with two requesters and TIMEOUT=16.
// Inputs change 1 time unit after each rising edge; outputs are compared
// 2 units after the edge, once the combinational paths have settled.
module tb_mem_bus_arbiter;

    localparam int NUM_REQ = 2;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_instr;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [4*NUM_REQ-1:0]  req_wstrb;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           req_rdata;
    logic                  mem_valid;
    logic                  mem_instr;
    logic                  mem_ready;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_rdata;
    logic                  console_valid;
    logic [7:0]            console_data;
    logic                  err_valid;
    logic [31:0]           err_addr;
    logic                  err_timeout;
    logic                  grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_instr     (req_instr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .req_ready     (req_ready),
        .req_rdata     (req_rdata),
        .mem_valid     (mem_valid),
        .mem_instr     (mem_instr),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata),
        .console_valid (console_valid),
        .console_data  (console_data),
        .err_valid     (err_valid),
        .err_addr      (err_addr),
        .err_timeout   (err_timeout),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic instr);
        req_valid[idx]          = valid;
        req_addr[32*idx +: 32]  = addr;
        req_wdata[32*idx +: 32] = wdata;
        req_wstrb[4*idx +: 4]   = wstrb;
        req_instr[idx]          = instr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_instr = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Reset state
        step();
        step();
        step();
        #1;
        checkOutput("rst mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("rst req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst grant_id", 32'(grant_id), 32'h0);
        checkOutput("rst err_valid", 32'(err_valid), 32'h0);
        checkOutput("rst err_addr", err_addr, 32'h0);
        checkOutput("rst console_valid", 32'(console_valid), 32'h0);
        resetn = 1'b1;
        step();

        // Requester 0 reads 0x100; memory answers in the third MEM cycle
        $display("[TB] single read");
        applyStimulus(0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
        #1;
        checkOutput("rd idle mem_valid", 32'(mem_valid), 32'h0);
        step(); #1;
        checkOutput("rd mem_valid", 32'(mem_valid), 32'h1);
        checkOutput("rd mem_addr", mem_addr, 32'h100);
        checkOutput("rd mem_wstrb", 32'(mem_wstrb), 32'h0);
        checkOutput("rd grant_id", 32'(grant_id), 32'h0);
        checkOutput("rd early ready", 32'(req_ready), 32'h0);
        step(); #1;
        checkOutput("rd hold mem_valid", 32'(mem_valid), 32'h1);
        checkOutput("rd hold ready", 32'(req_ready), 32'h0);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("rd req_ready", 32'(req_ready), 32'h1);
        checkOutput("rd req_rdata", req_rdata, 32'hDEAD_BEEF);
        checkOutput("rd err_valid", 32'(err_valid), 32'h0);
        step();
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        mem_ready = 1'b0;
        #1;
        checkOutput("rd drop mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("rd after ready", 32'(req_ready), 32'h0);

        // Both requesters continuously valid; requester 0 was served last,
        // so grants run 1,0,1,0
        $display("[TB] round robin");
        applyStimulus(0, 1'b1, 32'h200, 32'h0, 4'h0, 1'b0);
        applyStimulus(1, 1'b1, 32'h300, 32'h0, 4'h0, 1'b0);
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rr idle mem_valid", 32'(mem_valid), 32'h0);
            step(); #1;
            checkOutput("rr grant_id", 32'(grant_id), (k % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("rr mem_addr", mem_addr, (k % 2 == 0) ? 32'h300 : 32'h200);
            checkOutput("rr req_ready", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
            checkOutput("rr req_rdata", req_rdata, 32'h1111_2222);
            step();
        end
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        // Console write of 0x41
        $display("[TB] console write");
        applyStimulus(0, 1'b1, 32'h1000_0000, 32'h0000_0041, 4'hF, 1'b0);
        #1;
        checkOutput("con idle mem_valid", 32'(mem_valid), 32'h0);
        step(); #1;
        checkOutput("con console_valid", 32'(console_valid), 32'h1);
        checkOutput("con console_data", 32'(console_data), 32'h41);
        checkOutput("con req_ready", 32'(req_ready), 32'h1);
        checkOutput("con req_rdata", req_rdata, 32'h0);
        checkOutput("con mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("con err_valid", 32'(err_valid), 32'h0);
        step();
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        checkOutput("con pulse end", 32'(console_valid), 32'h0);
        checkOutput("con after ready", 32'(req_ready), 32'h0);
        checkOutput("con after mem_valid", 32'(mem_valid), 32'h0);

        // Out-of-range read at MEM_SIZE by requester 1
        $display("[TB] out of range");
        applyStimulus(1, 1'b1, 32'h0010_0000, 32'h0, 4'h0, 1'b0);
        step(); #1;
        checkOutput("oor err_valid", 32'(err_valid), 32'h1);
        checkOutput("oor err_addr", err_addr, 32'h0010_0000);
        checkOutput("oor err_timeout", 32'(err_timeout), 32'h0);
        checkOutput("oor req_ready", 32'(req_ready), 32'h2);
        checkOutput("oor req_rdata", req_rdata, 32'h0);
        checkOutput("oor mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("oor grant_id", 32'(grant_id), 32'h1);
        step();
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        checkOutput("oor pulse end", 32'(err_valid), 32'h0);
        checkOutput("oor err_addr held", err_addr, 32'h0010_0000);

        // Watchdog: mem_valid stays high 16 cycles, forced completion in the last
        $display("[TB] watchdog timeout");
        applyStimulus(1, 1'b1, 32'h400, 32'h0, 4'h0, 1'b1);
        step();
        for (int i = 0; i < 15; i++) begin
            #1;
            checkOutput("wd wait mem_valid", 32'(mem_valid), 32'h1);
            checkOutput("wd wait ready", 32'(req_ready), 32'h0);
            step();
        end
        #1;
        checkOutput("wd req_ready", 32'(req_ready), 32'h2);
        checkOutput("wd err_valid", 32'(err_valid), 32'h1);
        checkOutput("wd err_timeout", 32'(err_timeout), 32'h1);
        checkOutput("wd err_addr", err_addr, 32'h400);
        checkOutput("wd req_rdata", req_rdata, 32'h0);
        checkOutput("wd mem_instr", 32'(mem_instr), 32'h1);
        step();
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        checkOutput("wd drop mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("wd err_timeout held", 32'(err_timeout), 32'h1);
        checkOutput("wd pulse end", 32'(err_valid), 32'h0);

        // mem_ready in the watchdog cycle wins over the timeout
        $display("[TB] late ready");
        applyStimulus(0, 1'b1, 32'h500, 32'h0, 4'h0, 1'b0);
        step();
        for (int i = 0; i < 15; i++) begin
            #1;
            checkOutput("late wait mem_valid", 32'(mem_valid), 32'h1);
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("late req_ready", 32'(req_ready), 32'h1);
        checkOutput("late req_rdata", req_rdata, 32'hCAFE_F00D);
        checkOutput("late err_valid", 32'(err_valid), 32'h0);
        checkOutput("late err_addr kept", err_addr, 32'h400);
        step();
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        #1;
        checkOutput("late drop mem_valid", 32'(mem_valid), 32'h0);

        // Reset during MEM (priority currently favours requester 1)
        $display("[TB] reset mid transaction");
        applyStimulus(1, 1'b1, 32'h600, 32'h0, 4'h0, 1'b0);
        step(); #1;
        checkOutput("mrst mem_valid", 32'(mem_valid), 32'h1);
        checkOutput("mrst grant_id", 32'(grant_id), 32'h1);
        step();
        resetn = 1'b0;
        #1;
        checkOutput("mrst no ready", 32'(req_ready), 32'h0);
        step();
        resetn = 1'b1;
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        checkOutput("mrst mem_valid low", 32'(mem_valid), 32'h0);
        checkOutput("mrst ready low", 32'(req_ready), 32'h0);
        checkOutput("mrst grant_id", 32'(grant_id), 32'h0);
        checkOutput("mrst err_addr", err_addr, 32'h0);
        step();
        applyStimulus(0, 1'b1, 32'h700, 32'h0, 4'h0, 1'b0);
        applyStimulus(1, 1'b1, 32'h800, 32'h0, 4'h0, 1'b0);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        checkOutput("post idle mem_valid", 32'(mem_valid), 32'h0);
        step(); #1;
        checkOutput("post grant_id", 32'(grant_id), 32'h0);
        checkOutput("post mem_addr", mem_addr, 32'h700);
        checkOutput("post req_ready", 32'(req_ready), 32'h1);
        checkOutput("post req_rdata", req_rdata, 32'h1234_5678);
        step();
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        mem_ready = 1'b0;
        #1;
        checkOutput("post drop mem_valid", 32'(mem_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
